// File: rtl/outlier_collector.sv
// outlier_collector
// Gathers outlier indices popped from the controller FIFO into a per-point
// mask, then streams every index that was not flagged as an outlier, in
// ascending order, over a valid/ready handshake. Frame size is clamped to the
// mask depth and any position outside the frame raises a sticky range error.

module outlier_collector #(
    parameter int N               = 16,
    parameter int POINT_CLOUD_MAX = 1024
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         start,
    input  logic [N-1:0] point_cloud_size,
    input  logic         empty,
    input  logic [N-1:0] outlier_pos_fifo,
    input  logic         controller_done,
    output logic         read_fifo,
    output logic         inlier_valid,
    output logic [N-1:0] inlier_pos,
    input  logic         inlier_ready,
    output logic [N-1:0] outlier_count,
    output logic         error_range,
    output logic         done
);

    localparam int IDXW = (POINT_CLOUD_MAX > 1) ? $clog2(POINT_CLOUD_MAX) : 1;
    localparam logic [N:0] MAX_SIZE = (N+1)'(POINT_CLOUD_MAX);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_CLEAR   = 3'd1;
    localparam logic [2:0] S_COLLECT = 3'd2;
    localparam logic [2:0] S_STREAM  = 3'd3;
    localparam logic [2:0] S_DONE    = 3'd4;

    logic [2:0]                 state;
    logic [N-1:0]               size_reg;
    logic                       oversize_reg;
    logic [N-1:0]               scan_idx;
    logic                       rd_prev;
    logic [POINT_CLOUD_MAX-1:0] mask;

    logic                       capture;
    logic                       cap_in_range;
    logic                       cap_dup;
    logic [IDXW-1:0]            cap_idx;
    logic [IDXW-1:0]            scan_bit;
    logic                       scan_end;
    logic                       scan_masked;
    logic                       start_oversize;

    // Pop pacing, capture qualification and scan decode for the current cycle
    always_comb begin
        read_fifo      = (state == S_COLLECT) && !empty && !rd_prev;
        capture        = (state == S_COLLECT) && rd_prev;
        cap_in_range   = outlier_pos_fifo < size_reg;
        cap_idx        = outlier_pos_fifo[IDXW-1:0];
        cap_dup        = mask[cap_idx];
        scan_end       = scan_idx >= size_reg;
        scan_bit       = scan_idx[IDXW-1:0];
        scan_masked    = mask[scan_bit];
        start_oversize = {1'b0, point_cloud_size} > MAX_SIZE;
    end

    // Outlier mask: wiped at the start of each frame, one bit set per new outlier
    always_ff @(posedge clock) begin
        if (state == S_CLEAR) begin
            mask <= '0;
        end else if (capture && cap_in_range) begin
            mask[cap_idx] <= 1'b1;
        end
    end

    // Frame sequencing, outlier bookkeeping and inlier streaming
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state         <= S_IDLE;
            size_reg      <= '0;
            oversize_reg  <= 1'b0;
            scan_idx      <= '0;
            rd_prev       <= 1'b0;
            inlier_valid  <= 1'b0;
            inlier_pos    <= '0;
            outlier_count <= '0;
            error_range   <= 1'b0;
            done          <= 1'b0;
        end else begin
            rd_prev <= read_fifo;
            case (state)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state        <= S_CLEAR;
                        done         <= 1'b0;
                        oversize_reg <= start_oversize;
                        size_reg     <= start_oversize ? MAX_SIZE[N-1:0] : point_cloud_size;
                    end
                end
                S_CLEAR: begin
                    outlier_count <= '0;
                    error_range   <= oversize_reg;
                    done          <= 1'b0;
                    scan_idx      <= '0;
                    state         <= S_COLLECT;
                end
                S_COLLECT: begin
                    if (capture) begin
                        if (!cap_in_range) begin
                            error_range <= 1'b1;
                        end else if (!cap_dup && (outlier_count != {N{1'b1}})) begin
                            outlier_count <= outlier_count + N'(1);
                        end
                    end
                    if (controller_done && empty && !rd_prev) begin
                        scan_idx <= '0;
                        state    <= S_STREAM;
                    end
                end
                S_STREAM: begin
                    if (inlier_valid) begin
                        if (inlier_ready) begin
                            inlier_valid <= 1'b0;
                            scan_idx     <= scan_idx + N'(1);
                        end
                    end else if (scan_end) begin
                        done  <= 1'b1;
                        state <= S_DONE;
                    end else if (scan_masked) begin
                        scan_idx <= scan_idx + N'(1);
                    end else begin
                        inlier_valid <= 1'b1;
                        inlier_pos   <= scan_idx;
                    end
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_outlier_collector.sv
// tb_outlier_collector
// Drives outlier_collector with a queue-based FIFO model and a handshake sink,
// and checks each frame against a set-based reference of outliers and inliers.

module tb_outlier_collector;

    localparam int N   = 16;
    localparam int MAX = 1024;

    logic         clock = 1'b0;
    logic         reset;
    logic         start;
    logic [N-1:0] point_cloud_size;
    logic         empty = 1'b1;
    logic [N-1:0] outlier_pos_fifo = '0;
    logic         controller_done;
    logic         read_fifo;
    logic         inlier_valid;
    logic [N-1:0] inlier_pos;
    logic         inlier_ready;
    logic [N-1:0] outlier_count;
    logic         error_range;
    logic         done;

    int checks = 0;
    int errors = 0;

    int  fifo_words[$];
    int  pre_q[$];
    int  trickle_q[$];
    int  got_q[$];
    int  exp_q[$];
    bit  seen[MAX];
    bit  pop_now = 1'b0;
    bit  prev_valid = 1'b0;
    bit  prev_ready = 1'b0;
    bit  prev_rd = 1'b0;
    int  prev_pos = 0;

    typedef struct {
        string name;
        int    size;
        int    nwords;
        int    w0, w1, w2, w3;
        int    exp_count;
        int    exp_err;
        int    exp_inliers;
    } vec_t;

    vec_t vecs[6];

    outlier_collector #(.N(N), .POINT_CLOUD_MAX(MAX)) dut (
        .clock            (clock),
        .reset            (reset),
        .start            (start),
        .point_cloud_size (point_cloud_size),
        .empty            (empty),
        .outlier_pos_fifo (outlier_pos_fifo),
        .controller_done  (controller_done),
        .read_fifo        (read_fifo),
        .inlier_valid     (inlier_valid),
        .inlier_pos       (inlier_pos),
        .inlier_ready     (inlier_ready),
        .outlier_count    (outlier_count),
        .error_range      (error_range),
        .done             (done)
    );

    // Free-running clock
    always #5 clock = ~clock;

    // FIFO model: a pop seen in a cycle returns its word on the following cycle
    always @(posedge clock) begin
        if (pop_now && fifo_words.size() > 0) begin
            outlier_pos_fifo <= N'(fifo_words.pop_front());
        end
        empty <= (fifo_words.size() == 0);
    end

    task automatic check_output(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, actual, expected);
        end
    endtask

    // Sink monitor: records accepted inliers, checks hold-while-stalled and pop spacing
    always @(negedge clock) begin
        if (!reset) begin
            prev_valid = 1'b0;
            prev_ready = 1'b0;
            prev_rd    = 1'b0;
        end else begin
            if (inlier_valid && inlier_ready) got_q.push_back(int'(inlier_pos));
            if (prev_valid && !prev_ready) begin
                check_output("hold_valid", inlier_valid, 1);
                check_output("hold_pos", inlier_pos, prev_pos);
            end
            if (read_fifo) check_output("pop_spacing", prev_rd, 0);
            prev_valid = inlier_valid;
            prev_ready = inlier_ready;
            prev_pos   = int'(inlier_pos);
            prev_rd    = read_fifo;
        end
        pop_now = read_fifo;
    end

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic start_frame(input int size);
        got_q.delete();
        foreach (pre_q[i]) fifo_words.push_back(pre_q[i]);
        point_cloud_size = N'(size);
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Reference: set of distinct in-range outliers, inliers are the complement in order
    task automatic compare_frame(input int size, input string tag);
        int eff;
        int cnt;
        int err;
        int bad;
        int all_words[$];
        eff = (size > MAX) ? MAX : size;
        err = (size > MAX) ? 1 : 0;
        cnt = 0;
        for (int i = 0; i < MAX; i++) seen[i] = 1'b0;
        all_words = pre_q;
        foreach (trickle_q[i]) all_words.push_back(trickle_q[i]);
        foreach (all_words[i]) begin
            if (all_words[i] >= eff) err = 1;
            else if (!seen[all_words[i]]) begin
                seen[all_words[i]] = 1'b1;
                cnt++;
            end
        end
        exp_q.delete();
        for (int i = 0; i < eff; i++) if (!seen[i]) exp_q.push_back(i);
        bad = 0;
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            if (got_q[i] != exp_q[i]) bad++;
        check_output({tag, "_count"}, outlier_count, cnt);
        check_output({tag, "_error_range"}, error_range, err);
        check_output({tag, "_inlier_total"}, got_q.size(), exp_q.size());
        check_output({tag, "_inlier_order"}, bad, 0);
        check_output({tag, "_valid_after_done"}, inlier_valid, 0);
        check_output({tag, "_fifo_drained"}, fifo_words.size(), 0);
    endtask

    // Feeds late outliers, signals controller completion and waits for done
    task automatic finish_frame(input int size, input int mode, input string tag);
        int cyc;
        foreach (trickle_q[i]) begin
            fifo_words.push_back(trickle_q[i]);
            repeat ($urandom_range(1, 3)) tick();
        end
        controller_done = 1'b1;
        cyc = 0;
        while (!done && cyc < 30000) begin
            inlier_ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
            tick();
            cyc++;
        end
        check_output({tag, "_done"}, done, 1);
        compare_frame(size, tag);
        controller_done = 1'b0;
        inlier_ready    = 1'b1;
    endtask

    task automatic apply_stimulus(input int size, input int mode, input string tag);
        start_frame(size);
        finish_frame(size, mode, tag);
    endtask

    task automatic check_reset_values(input string tag);
        check_output({tag, "_read_fifo"}, read_fifo, 0);
        check_output({tag, "_inlier_valid"}, inlier_valid, 0);
        check_output({tag, "_inlier_pos"}, inlier_pos, 0);
        check_output({tag, "_outlier_count"}, outlier_count, 0);
        check_output({tag, "_error_range"}, error_range, 0);
        check_output({tag, "_done"}, done, 0);
    endtask

    // Main sequence: reset, vector table, multi-cycle corner cases, random frames
    initial begin
        int c;
        reset            = 1'b0;
        start            = 1'b0;
        point_cloud_size = '0;
        controller_done  = 1'b0;
        inlier_ready     = 1'b1;

        vecs[0] = '{"two_outliers", 8, 2, 2, 5, 0, 0, 2, 0, 6};
        vecs[1] = '{"dup_and_range", 8, 3, 3, 3, 9, 0, 1, 1, 7};
        vecs[2] = '{"no_outliers", 4, 0, 0, 0, 0, 0, 0, 0, 4};
        vecs[3] = '{"edge_indices", 8, 2, 7, 0, 0, 0, 2, 0, 6};
        vecs[4] = '{"pos_eq_size", 8, 1, 8, 0, 0, 0, 0, 1, 8};
        vecs[5] = '{"all_outliers", 3, 4, 2, 1, 0, 1, 3, 0, 0};

        repeat (3) tick();
        check_reset_values("reset");
        reset = 1'b1;
        tick();

        for (int v = 0; v < 6; v++) begin
            pre_q.delete();
            trickle_q.delete();
            if (vecs[v].nwords > 0) pre_q.push_back(vecs[v].w0);
            if (vecs[v].nwords > 1) pre_q.push_back(vecs[v].w1);
            if (vecs[v].nwords > 2) pre_q.push_back(vecs[v].w2);
            if (vecs[v].nwords > 3) pre_q.push_back(vecs[v].w3);
            apply_stimulus(vecs[v].size, 0, vecs[v].name);
            check_output({vecs[v].name, "_tbl_count"}, outlier_count, vecs[v].exp_count);
            check_output({vecs[v].name, "_tbl_err"}, error_range, vecs[v].exp_err);
            check_output({vecs[v].name, "_tbl_inliers"}, got_q.size(), vecs[v].exp_inliers);
        end

        // Stall on index 1 for five cycles
        pre_q.delete();
        trickle_q.delete();
        controller_done = 1'b1;
        inlier_ready    = 1'b0;
        start_frame(4);
        c = 0;
        while (!inlier_valid && c < 20) begin tick(); c++; end
        check_output("stall_first_valid", inlier_valid, 1);
        inlier_ready = 1'b1;
        tick();
        inlier_ready = 1'b0;
        c = 0;
        while (!(inlier_valid && inlier_pos == 1) && c < 20) begin tick(); c++; end
        check_output("stall_pos", inlier_pos, 1);
        repeat (5) begin
            tick();
            check_output("stall_held_valid", inlier_valid, 1);
            check_output("stall_held_pos", inlier_pos, 1);
        end
        finish_frame(4, 0, "stall");

        // Empty frame finishes quickly with no inliers
        controller_done = 1'b1;
        start_frame(0);
        c = 0;
        while (!done && c < 4) begin
            check_output("size0_no_valid", inlier_valid, 0);
            tick();
            c++;
        end
        check_output("size0_done_latency", done, 1);
        check_output("size0_inliers", got_q.size(), 0);
        controller_done = 1'b0;

        // Oversize frame is clamped and flagged right after clear
        start_frame(2000);
        tick();
        check_output("oversize_err_after_clear", error_range, 1);
        finish_frame(2000, 0, "oversize");

        // Asynchronous reset in the middle of streaming, then a fresh frame
        controller_done = 1'b1;
        start_frame(10);
        c = 0;
        while (!(inlier_valid && inlier_pos == 5) && c < 100) begin tick(); c++; end
        check_output("midstream_reached_5", inlier_pos, 5);
        reset = 1'b0;
        #1;
        check_reset_values("midstream_reset");
        tick();
        reset = 1'b1;
        controller_done = 1'b0;
        tick();
        pre_q.delete();
        pre_q.push_back(4);
        apply_stimulus(10, 1, "after_reset");

        // Randomized frames with trickled outliers and random back-pressure
        for (int f = 0; f < 6; f++) begin
            int size;
            size = $urandom_range(1, 40);
            pre_q.delete();
            trickle_q.delete();
            repeat ($urandom_range(0, 4)) pre_q.push_back($urandom_range(0, size + 3));
            repeat ($urandom_range(0, 4)) trickle_q.push_back($urandom_range(0, size + 3));
            apply_stimulus(size, 1, "random");
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/outlier_collector.md
OUTLIER_COLLECTOR -- requirements
Module: outlier_collector

Interface
REQ-001 Parameter N, default 16, width of point positions and counters.
REQ-002 Parameter POINT_CLOUD_MAX, default 1024, number of mask bits (maximum cloud size).
REQ-003 clock  input  1  single system clock; all state changes on rising edge.
REQ-004 reset  input  1  asynchronous, active-low reset.
REQ-005 start  input  1  single-cycle pulse beginning a new frame.
REQ-006 point_cloud_size  input  N  number of points in the frame, sampled on start.
REQ-007 empty  input  1  Controller outlier FIFO empty flag.
REQ-008 outlier_pos_fifo  input  N  Controller FIFO read data, valid the cycle after read_fifo.
REQ-009 controller_done  input  1  Controller finished classifying all points.
REQ-010 read_fifo  output  1  FIFO pop strobe, one cycle per word.
REQ-011 inlier_valid  output  1  inlier_pos holds a valid inlier index.
REQ-012 inlier_pos  output  N  index of a point not flagged as outlier.
REQ-013 inlier_ready  input  1  downstream accepts inlier_pos when high with inlier_valid.
REQ-014 outlier_count  output  N  number of distinct in-range outliers recorded this frame.
REQ-015 error_range  output  1  sticky: out-of-range position or oversize frame seen this frame.
REQ-016 done  output  1  frame fully streamed; held until next start or reset.

Function
REQ-017 States IDLE, CLEAR, COLLECT, STREAM, DONE; one-hot or binary encoding free.
REQ-018 IDLE/DONE: start=1 -> CLEAR; start ignored in all other states.
REQ-019 CLEAR (exactly 1 cycle): all mask bits 0, outlier_count 0, error_range 0, done 0, size register loaded -> COLLECT.
REQ-020 Size rule: point_cloud_size > POINT_CLOUD_MAX -> size register = POINT_CLOUD_MAX, error_range set in CLEAR.
REQ-021 COLLECT: read_fifo=1 iff empty=0 and read_fifo was 0 the previous cycle (max one pop per 2 cycles).
REQ-022 Cycle after read_fifo=1: capture outlier_pos_fifo p; p < size and mask[p]=0 -> mask[p]=1, outlier_count+1.
REQ-023 Duplicate p (mask[p]=1) -> no change; p >= size -> mask unchanged, error_range=1.
REQ-024 COLLECT -> STREAM when controller_done=1, empty=1 and no read outstanding (read_fifo=0 previous cycle); scan index=0.
REQ-025 STREAM: index with mask=1 skipped in 1 cycle; mask=0 -> inlier_valid=1, inlier_pos=index, held stable until inlier_ready=1.
REQ-026 Transfer completes on cycle with inlier_valid=1 and inlier_ready=1; index advances next cycle.
REQ-027 After index size-1 handled (or size=0 immediately) -> DONE; inlier_valid=0, done=1.
REQ-028 read_fifo=0 outside COLLECT; inlier_valid=0 outside STREAM.
REQ-029 outlier_count saturates at 2^N-1; never wraps.
REQ-030 inlier_pos ascending, each inlier exactly once; outliers + inliers = size when error_range=0.

Reset
REQ-031 reset=0 forces IDLE asynchronously, any state incl. mid-STREAM.
REQ-032 Reset values: read_fifo 0, inlier_valid 0, inlier_pos 0, outlier_count 0, error_range 0, done 0; mask contents undefined (cleared by CLEAR).
REQ-033 First start after reset release behaves as REQ-018.

Verification
REQ-034 size=8, FIFO {2,5}, controller_done -> outlier_count=2, inliers 0,1,3,4,6,7, done=1, error_range=0.
REQ-035 size=8, FIFO {3,3,9} -> outlier_count=1, error_range=1, 7 inliers (3 absent).
REQ-036 size=4, no outliers, inlier_ready low 5 cycles on index 1 -> inlier_pos=1 held stable, then 2,3; done=1.
REQ-037 size=0 with start, controller_done=1, empty=1 -> no inlier_valid, done=1 within 4 cycles of start.
REQ-038 size=2000 (MAX 1024) -> error_range=1 after CLEAR, stream covers indices 0..1023 only.
REQ-039 reset=0 during STREAM at index 5 -> all outputs at reset values same cycle; next start yields full fresh frame.
